// File: rtl/frame_transfer_sink_if.sv
// Macroblock type carried on the frame transfer link, plus the link's
// pixel-in / word-out handshake bundle.
package frame_transfer_sink_pkg;
    typedef enum logic [1:0] {
        MB_INTRA = 2'd0,
        MB_INTER = 2'd1,
        MB_BIDIR = 2'd2,
        MB_SKIP  = 2'd3
    } teMacroBlockType;
endpackage

interface frame_transfer_sink_if;
    // upstream pixel side
    logic                                     ul1Active;
    frame_transfer_sink_pkg::teMacroBlockType eMacroBlockType;
    logic [23:0]                              ul24Rgb24Data;
    logic                                     ul1MacroBlockEnd;
    logic                                     ul1Ready;
    // downstream word side
    logic                                     ul1OutValid;
    logic [23:0]                              ul24OutRgb24Data;
    frame_transfer_sink_pkg::teMacroBlockType eOutMacroBlockType;
    logic                                     ul1OutLast;
    logic                                     ul1OutReady;

    // Source of pixels and consumer of words
    modport master (
        output ul1Active, eMacroBlockType, ul24Rgb24Data, ul1MacroBlockEnd,
        output ul1OutReady,
        input  ul1Ready,
        input  ul1OutValid, ul24OutRgb24Data, eOutMacroBlockType, ul1OutLast
    );

    // The sink itself
    modport slave (
        input  ul1Active, eMacroBlockType, ul24Rgb24Data, ul1MacroBlockEnd,
        input  ul1OutReady,
        output ul1Ready,
        output ul1OutValid, ul24OutRgb24Data, eOutMacroBlockType, ul1OutLast
    );
endinterface

// File: rtl/frame_transfer_sink.sv
// Destination end of the frame transfer link: accepts RGB24 macroblock
// pixels, checks macroblock framing against MB_PIXELS, buffers words in a
// first-word-fall-through FIFO and re-emits them on a valid/ready stream.
module frame_transfer_sink
    import frame_transfer_sink_pkg::*;
#(
    parameter int MB_PIXELS = 256,
    parameter int DEPTH     = 16
) (
    input  logic                 ul1Clock,
    input  logic                 ul1Reset,
    frame_transfer_sink_if.slave link,
    output logic                 ul1FrameDone,
    output logic [15:0]          ul16MbCount,
    output logic                 ul1ErrEarlyEnd,
    output logic                 ul1ErrMissingEnd,
    output logic                 ul1ErrTruncated,
    input  logic                 ul1ClearErr
);

    localparam int CNT_W  = (MB_PIXELS > 1) ? $clog2(MB_PIXELS) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = PTR_W + 1;
    localparam int TYPE_W = $bits(teMacroBlockType);
    localparam int WORD_W = 24 + TYPE_W + 1;

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(MB_PIXELS - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RX   = 1'b1
    } state_t;

    // Macroblock counter saturates instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [15:0]            mb_cnt_q, mb_cnt_d;
    teMacroBlockType        mb_type_q, mb_type_d;
    logic                   done_q;
    logic                   err_early_q, err_missing_q, err_trunc_q;

    logic [CNT_W-1:0]       pix_c;
    logic [15:0]            mb_base;
    logic                   set_early, set_missing, set_trunc, frame_end;
    logic                   word_last;
    teMacroBlockType        word_type;

    // stage p0: pixel presented at the link input
    logic                   vld_p0;
    logic [WORD_W-1:0]      word_p0;

    // stage p1: FIFO head presented downstream
    logic [WORD_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   ready_q;
    logic                   vld_p1;
    logic                   pop_p1;
    logic [WORD_W-1:0]      word_p1;

    assign link.ul1Ready = ready_q & ~ul1Reset;
    assign vld_p0        = link.ul1Active & link.ul1Ready;
    assign word_p0       = {link.ul24Rgb24Data, word_type, word_last};

    // Framing state machine: pixel counter, type latch, errors to set, frame end
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        mb_cnt_d    = mb_cnt_q;
        mb_type_d   = mb_type_q;
        pix_c       = pix_cnt_q;
        mb_base     = mb_cnt_q;
        set_early   = 1'b0;
        set_missing = 1'b0;
        set_trunc   = 1'b0;
        frame_end   = 1'b0;
        word_last   = 1'b0;
        word_type   = mb_type_q;

        case (state_q)
            S_IDLE: begin
                if (link.ul1Active) begin
                    // a pixel accepted on this same edge is pixel 0 of a fresh frame
                    state_d   = S_RX;
                    pix_c     = '0;
                    mb_base   = '0;
                    pix_cnt_d = '0;
                    mb_cnt_d  = '0;
                end
            end
            S_RX: begin
                if (!link.ul1Active) begin
                    state_d   = S_IDLE;
                    frame_end = 1'b1;
                    if (pix_cnt_q != '0) begin
                        set_trunc = 1'b1;
                        pix_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (vld_p0) begin
            if (pix_c == '0) begin
                word_type = link.eMacroBlockType;
                mb_type_d = link.eMacroBlockType;
            end
            if (link.ul1MacroBlockEnd || (pix_c == LAST_PIX)) begin
                // every close (normal, early or forced) ends the macroblock
                word_last = 1'b1;
                pix_cnt_d = '0;
                mb_cnt_d  = sat_inc(mb_base);
                set_early   = link.ul1MacroBlockEnd && (pix_c != LAST_PIX);
                set_missing = !link.ul1MacroBlockEnd;
            end else begin
                pix_cnt_d = pix_c + CNT_W'(1);
            end
        end
    end

    // Framing control registers
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            mb_cnt_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            mb_cnt_q  <= mb_cnt_d;
            done_q    <= frame_end;
        end
    end

    // Latched macroblock type (data path, only observed through FIFO words)
    always_ff @(posedge ul1Clock) begin
        mb_type_q <= mb_type_d;
    end

    // Sticky framing errors; a clear wins over a set in the same cycle
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset || ul1ClearErr) begin
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            err_trunc_q   <= 1'b0;
        end else begin
            if (set_early)   err_early_q   <= 1'b1;
            if (set_missing) err_missing_q <= 1'b1;
            if (set_trunc)   err_trunc_q   <= 1'b1;
        end
    end

    assign vld_p1  = (occ_q != '0);
    assign pop_p1  = vld_p1 & link.ul1OutReady;
    assign word_p1 = mem[rd_ptr_q];
    assign occ_d   = occ_q + OCC_W'(vld_p0) - OCC_W'(pop_p1);

    // FIFO pointers, occupancy and registered ready (from next occupancy)
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (vld_p0) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_p1) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q   <= occ_d;
            ready_q <= (occ_d < DEPTH_OCC);
        end
    end

    // FIFO storage
    always_ff @(posedge ul1Clock) begin
        if (vld_p0) mem[wr_ptr_q] <= word_p0;
    end

    // Outputs are forced to zero while the FIFO is empty
    assign link.ul1OutValid        = vld_p1;
    assign link.ul24OutRgb24Data   = vld_p1 ? word_p1[WORD_W-1 -: 24] : 24'd0;
    assign link.eOutMacroBlockType = vld_p1 ? teMacroBlockType'(word_p1[TYPE_W:1]) : MB_INTRA;
    assign link.ul1OutLast         = vld_p1 & word_p1[0];

    assign ul1FrameDone     = done_q;
    assign ul16MbCount      = mb_cnt_q;
    assign ul1ErrEarlyEnd   = err_early_q;
    assign ul1ErrMissingEnd = err_missing_q;
    assign ul1ErrTruncated  = err_trunc_q;

endmodule

// File: tb/tb_frame_transfer_sink.sv
// Bench for frame_transfer_sink: hand-written vector table, directed
// macroblock scenarios and randomized traffic, all compared against a
// queue-based reference of the link's behaviour.
module tb_frame_transfer_sink;
    import frame_transfer_sink_pkg::*;

    localparam int MB    = 256;
    localparam int DEPTH = 16;

    logic        ul1Clock = 1'b0;
    logic        ul1Reset;
    logic        ul1ClearErr;
    logic        ul1FrameDone;
    logic [15:0] ul16MbCount;
    logic        ul1ErrEarlyEnd, ul1ErrMissingEnd, ul1ErrTruncated;

    frame_transfer_sink_if ifc();

    frame_transfer_sink #(.MB_PIXELS(MB), .DEPTH(DEPTH)) dut (
        .ul1Clock         (ul1Clock),
        .ul1Reset         (ul1Reset),
        .link             (ifc),
        .ul1FrameDone     (ul1FrameDone),
        .ul16MbCount      (ul16MbCount),
        .ul1ErrEarlyEnd   (ul1ErrEarlyEnd),
        .ul1ErrMissingEnd (ul1ErrMissingEnd),
        .ul1ErrTruncated  (ul1ErrTruncated),
        .ul1ClearErr      (ul1ClearErr)
    );

    always #5 ul1Clock = ~ul1Clock;

    typedef struct {
        logic [23:0]     data;
        teMacroBlockType typ;
        bit              last;
    } word_t;

    // reference model state
    word_t           exp_q[$];
    bit              m_inframe, m_ready, m_done, m_early, m_miss, m_trunc;
    int              m_idx, m_mbcnt;
    teMacroBlockType m_type;

    int checks = 0;
    int errors = 0;
    int n_pops, n_lasts, n_acc, n_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input bit act, input teMacroBlockType t, input logic [23:0] d,
                         input bit e, input bit ordy, input bit clr);
        ifc.ul1Active        = act;
        ifc.eMacroBlockType  = t;
        ifc.ul24Rgb24Data    = d;
        ifc.ul1MacroBlockEnd = e;
        ifc.ul1OutReady      = ordy;
        ul1ClearErr          = clr;
    endtask

    // Compare every observable output against the reference after an edge.
    task automatic post_check();
        chk("ready", 32'(ifc.ul1Ready), 32'(!ul1Reset && m_ready));
        chk("valid", 32'(ifc.ul1OutValid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("data", 32'(ifc.ul24OutRgb24Data), 32'(exp_q[0].data));
            chk("type", 32'(ifc.eOutMacroBlockType), 32'(exp_q[0].typ));
            chk("last", 32'(ifc.ul1OutLast), 32'(exp_q[0].last));
        end else if (ul1Reset) begin
            chk("rst_data", 32'(ifc.ul24OutRgb24Data), 32'd0);
            chk("rst_type", 32'(ifc.eOutMacroBlockType), 32'd0);
            chk("rst_last", 32'(ifc.ul1OutLast), 32'd0);
        end
        chk("mbcount", 32'(ul16MbCount), 32'(m_mbcnt));
        chk("framedone", 32'(ul1FrameDone), 32'(m_done));
        chk("err_early", 32'(ul1ErrEarlyEnd), 32'(m_early));
        chk("err_missing", 32'(ul1ErrMissingEnd), 32'(m_miss));
        chk("err_trunc", 32'(ul1ErrTruncated), 32'(m_trunc));
        if (ul1FrameDone) n_done++;
    endtask

    // One clock: update the reference from the driven inputs, then advance.
    task automatic tick();
        bit    acc, popm, start, stop, e_set, x_set, t_set;
        word_t w;
        #1;
        if (ifc.ul1OutValid && ifc.ul1OutReady && !ul1Reset) begin
            n_pops++;
            if (ifc.ul1OutLast) n_lasts++;
        end
        if (ifc.ul1Active && ifc.ul1Ready && !ul1Reset) n_acc++;
        if (ul1Reset) begin
            exp_q.delete();
            m_inframe = 0; m_ready = 1; m_done = 0;
            m_early = 0; m_miss = 0; m_trunc = 0;
            m_idx = 0; m_mbcnt = 0;
        end else begin
            acc   = ifc.ul1Active && m_ready;
            popm  = (exp_q.size() != 0) && ifc.ul1OutReady;
            start = !m_inframe && ifc.ul1Active;
            stop  = m_inframe && !ifc.ul1Active;
            e_set = 0; x_set = 0; t_set = 0;
            if (start) begin
                m_inframe = 1; m_idx = 0; m_mbcnt = 0;
            end
            if (acc) begin
                if (m_idx == 0) m_type = ifc.eMacroBlockType;
                w.data = ifc.ul24Rgb24Data;
                w.typ  = m_type;
                w.last = ifc.ul1MacroBlockEnd || (m_idx == MB - 1);
                if (ifc.ul1MacroBlockEnd && m_idx != MB - 1) e_set = 1;
                if (!ifc.ul1MacroBlockEnd && m_idx == MB - 1) x_set = 1;
                if (w.last) begin
                    m_idx   = 0;
                    m_mbcnt = (m_mbcnt < 65535) ? m_mbcnt + 1 : 65535;
                end else begin
                    m_idx++;
                end
            end
            m_done = stop;
            if (stop) begin
                m_inframe = 0;
                if (m_idx != 0) t_set = 1;
                m_idx = 0;
            end
            if (popm) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(w);
            m_ready = (exp_q.size() < DEPTH);
            if (ul1ClearErr) begin
                m_early = 0; m_miss = 0; m_trunc = 0;
            end else begin
                m_early = m_early | e_set;
                m_miss  = m_miss  | x_set;
                m_trunc = m_trunc | t_set;
            end
        end
        @(posedge ul1Clock);
        #1;
        post_check();
    endtask

    typedef struct {
        int              rst, act;
        teMacroBlockType typ;
        logic [23:0]     dat;
        int              mend, ordy, clr;
        int              rdy, vld;
        logic [23:0]     odat;
        teMacroBlockType otyp;
        int              olast, mbc, done, early, trunc;
    } vec_t;

    vec_t vt[10];

    bit              r_act, r_end, r_ordy, r_clr, r_rst;
    teMacroBlockType r_typ;

    initial begin
        ul1Reset = 1'b1;
        drive(0, MB_INTRA, 24'd0, 0, 0, 0);
        n_pops = 0; n_lasts = 0; n_acc = 0; n_done = 0;

        //          rst act typ       dat     end rdy clr  rdy vld odat    otyp      last mbc done early trunc
        vt[0] = '{1, 0, MB_INTRA, 24'h0,  0, 0, 0,  0, 0, 24'h0,  MB_INTRA, 0, 0, 0, 0, 0};
        vt[1] = '{0, 0, MB_INTRA, 24'h0,  0, 0, 0,  1, 0, 24'h0,  MB_INTRA, 0, 0, 0, 0, 0};
        vt[2] = '{0, 1, MB_INTER, 24'hAA, 1, 0, 0,  1, 1, 24'hAA, MB_INTER, 1, 1, 0, 1, 0};
        vt[3] = '{0, 1, MB_SKIP,  24'hBB, 0, 1, 0,  1, 1, 24'hBB, MB_SKIP,  0, 1, 0, 1, 0};
        vt[4] = '{0, 1, MB_INTRA, 24'hCC, 1, 0, 1,  1, 1, 24'hBB, MB_SKIP,  0, 2, 0, 0, 0};
        vt[5] = '{0, 0, MB_INTRA, 24'h0,  0, 1, 0,  1, 1, 24'hCC, MB_SKIP,  1, 2, 1, 0, 0};
        vt[6] = '{0, 0, MB_INTRA, 24'h0,  0, 1, 0,  1, 0, 24'h0,  MB_INTRA, 0, 2, 0, 0, 0};
        vt[7] = '{0, 1, MB_INTER, 24'hDD, 0, 1, 0,  1, 1, 24'hDD, MB_INTER, 0, 0, 0, 0, 0};
        vt[8] = '{0, 0, MB_INTRA, 24'h0,  0, 1, 0,  1, 0, 24'h0,  MB_INTRA, 0, 0, 1, 0, 1};
        vt[9] = '{0, 0, MB_INTRA, 24'h0,  0, 1, 1,  1, 0, 24'h0,  MB_INTRA, 0, 0, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            ul1Reset = (vt[i].rst != 0);
            drive(vt[i].act != 0, vt[i].typ, vt[i].dat, vt[i].mend != 0, vt[i].ordy != 0, vt[i].clr != 0);
            tick();
            chk($sformatf("vec%0d_ready", i), 32'(ifc.ul1Ready), 32'(vt[i].rdy));
            chk($sformatf("vec%0d_valid", i), 32'(ifc.ul1OutValid), 32'(vt[i].vld));
            if (vt[i].vld != 0 || vt[i].rst != 0) begin
                chk($sformatf("vec%0d_data", i), 32'(ifc.ul24OutRgb24Data), 32'(vt[i].odat));
                chk($sformatf("vec%0d_type", i), 32'(ifc.eOutMacroBlockType), 32'(vt[i].otyp));
                chk($sformatf("vec%0d_last", i), 32'(ifc.ul1OutLast), 32'(vt[i].olast));
            end
            chk($sformatf("vec%0d_mbcount", i), 32'(ul16MbCount), 32'(vt[i].mbc));
            chk($sformatf("vec%0d_done", i), 32'(ul1FrameDone), 32'(vt[i].done));
            chk($sformatf("vec%0d_early", i), 32'(ul1ErrEarlyEnd), 32'(vt[i].early));
            chk($sformatf("vec%0d_trunc", i), 32'(ul1ErrTruncated), 32'(vt[i].trunc));
        end
        ul1Reset = 1'b0;

        // clean frame: two full macroblocks, data = index
        n_pops = 0; n_lasts = 0; n_done = 0;
        for (int i = 0; i < 512; i++) begin
            drive(1, (i < 256) ? MB_INTER : MB_BIDIR, 24'(i), (i == 255) || (i == 511), 1, 0);
            tick();
        end
        drive(0, MB_INTRA, 24'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("clean_words", 32'(n_pops), 32'd512);
        chk("clean_lasts", 32'(n_lasts), 32'd2);
        chk("clean_mbcount", 32'(ul16MbCount), 32'd2);
        chk("clean_done_pulses", 32'(n_done), 32'd1);
        chk("clean_errors", 32'({ul1ErrEarlyEnd, ul1ErrMissingEnd, ul1ErrTruncated}), 32'd0);

        // backpressure: downstream stalled while the source keeps sending
        n_acc = 0; n_pops = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, MB_BIDIR, 24'h100 + 24'(n_acc), 0, 0, 0);
            tick();
        end
        chk("bp_accepts", 32'(n_acc), 32'd16);
        chk("bp_ready_low", 32'(ifc.ul1Ready), 32'd0);
        drive(1, MB_BIDIR, 24'h100 + 24'(n_acc), 0, 1, 0);
        tick();
        chk("bp_ready_back", 32'(ifc.ul1Ready), 32'd1);
        for (int i = 0; i < 30; i++) begin
            drive(1, MB_BIDIR, 24'h100 + 24'(n_acc), 0, 1, 0);
            tick();
        end
        drive(0, MB_INTRA, 24'd0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("bp_total_accepts", 32'(n_acc), 32'd46);
        chk("bp_no_loss", 32'(n_pops), 32'(n_acc));
        chk("bp_truncated", 32'(ul1ErrTruncated), 32'd1);
        drive(0, MB_INTRA, 24'd0, 0, 1, 1);
        tick();

        // early end on pixel 99, then a fresh macroblock with a new type
        for (int i = 0; i < 100; i++) begin
            drive(1, MB_INTER, 24'(i), i == 99, 1, 0);
            tick();
        end
        chk("early_flag", 32'(ul1ErrEarlyEnd), 32'd1);
        chk("early_last", 32'(ifc.ul1OutLast), 32'd1);
        chk("early_word", 32'(ifc.ul24OutRgb24Data), 32'd99);
        drive(1, MB_SKIP, 24'd100, 0, 1, 0);
        tick();
        chk("early_newtype", 32'(ifc.eOutMacroBlockType), 32'(MB_SKIP));
        drive(1, MB_INTRA, 24'd101, 0, 1, 0);
        tick();
        chk("midmb_type_held", 32'(ifc.eOutMacroBlockType), 32'(MB_SKIP));
        drive(0, MB_INTRA, 24'd0, 0, 1, 0);
        tick(); tick();
        drive(0, MB_INTRA, 24'd0, 0, 1, 1);
        tick();

        // missing end: 300 pixels without an end flag, then frame drop
        for (int i = 0; i < 300; i++) begin
            drive(1, MB_BIDIR, 24'(i), 0, 1, 0);
            tick();
            if (i == 255) begin
                chk("missing_last", 32'(ifc.ul1OutLast), 32'd1);
                chk("missing_word", 32'(ifc.ul24OutRgb24Data), 32'd255);
                chk("missing_flag", 32'(ul1ErrMissingEnd), 32'd1);
            end
        end
        drive(0, MB_INTRA, 24'd0, 0, 1, 0);
        tick();
        chk("truncated_flag", 32'(ul1ErrTruncated), 32'd1);
        tick();
        drive(0, MB_INTRA, 24'd0, 0, 1, 1);
        tick();

        // clear coinciding with new error events keeps the flags low
        for (int i = 0; i < 260; i++) begin
            drive(1, MB_INTER, 24'(i), 0, 1, i == 255);
            tick();
            if (i == 255) chk("clear_beats_missing", 32'(ul1ErrMissingEnd), 32'd0);
        end
        drive(0, MB_INTRA, 24'd0, 0, 1, 1);
        tick();
        chk("clear_beats_trunc", 32'(ul1ErrTruncated), 32'd0);
        chk("clear_frame_done", 32'(ul1FrameDone), 32'd1);
        drive(0, MB_INTRA, 24'd0, 0, 1, 0);
        tick();

        // reset mid-macroblock with 8 words buffered
        for (int i = 0; i < 8; i++) begin
            drive(1, MB_SKIP, 24'h300 + 24'(i), 0, 0, 0);
            tick();
        end
        ul1Reset = 1'b1;
        drive(0, MB_INTRA, 24'd0, 0, 0, 0);
        tick();
        chk("rst_ready", 32'(ifc.ul1Ready), 32'd0);
        chk("rst_valid", 32'(ifc.ul1OutValid), 32'd0);
        chk("rst_outdata", 32'(ifc.ul24OutRgb24Data), 32'd0);
        chk("rst_mbcount", 32'(ul16MbCount), 32'd0);
        chk("rst_flags", 32'({ul1FrameDone, ul1ErrEarlyEnd, ul1ErrMissingEnd, ul1ErrTruncated}), 32'd0);
        ul1Reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(ifc.ul1Ready), 32'd1);
        for (int i = 0; i < 256; i++) begin
            drive(1, MB_INTER, 24'(i), i == 255, 1, 0);
            tick();
        end
        chk("post_rst_close", 32'(ifc.ul1OutLast), 32'd1);
        chk("post_rst_noerr", 32'({ul1ErrEarlyEnd, ul1ErrMissingEnd}), 32'd0);
        chk("post_rst_mbcount", 32'(ul16MbCount), 32'd1);
        drive(0, MB_INTRA, 24'd0, 0, 1, 0);
        tick(); tick();

        // randomized traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            r_act  = ($urandom_range(0, 299) != 0);
            r_end  = (m_idx == MB - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) == 0);
            r_ordy = ($urandom_range(0, 3) != 0);
            r_clr  = ($urandom_range(0, 99) == 0);
            r_rst  = ($urandom_range(0, 999) == 0);
            r_typ  = teMacroBlockType'($urandom_range(0, 3));
            ul1Reset = r_rst;
            drive(r_act, r_typ, 24'($urandom), r_end, r_ordy, r_clr);
            tick();
        end
        ul1Reset = 1'b0;
        drive(0, MB_INTRA, 24'd0, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("final_drained", 32'(ifc.ul1OutValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_transfer_sink.md
Name: frame_transfer_sink

Overview:
- Destination end of the frame transfer link. Accepts RGB24 macroblock pixels from an upstream frame source under ul1Active/ul1Ready flow control.
- Checks macroblock framing against a fixed macroblock size and buffers accepted pixels in a first-word-fall-through FIFO.
- Re-emits pixels on a valid/ready stream toward downstream processing (encoder or memory writer).
- Reports frame completion and framing errors.

Parameters:
MB_PIXELS, 256, pixels per macroblock (16x16); must be ≥2.
DEPTH, 16, FIFO depth in words; power of two, ≥2.

Ports:
ul1Clock  in  1  common clock; all logic on the rising edge.
ul1Reset  in  1  synchronous, active-high reset.
ul1Active  in  1  source is transferring a frame.
eMacroBlockType  in  teMacroBlockType  macroblock type from the source.
ul24Rgb24Data  in  24  RGB24 pixel.
ul1MacroBlockEnd  in  1  last pixel of the macroblock.
ul1Ready  out  1  sink can accept a pixel this cycle.
ul1OutValid  out  1  output word available.
ul24OutRgb24Data  out  24  output pixel.
eOutMacroBlockType  out  teMacroBlockType  type latched at the macroblock's first pixel.
ul1OutLast  out  1  word closes a macroblock.
ul1OutReady  in  1  downstream accepts the word.
ul1FrameDone  out  1  one-cycle pulse at frame end.
ul16MbCount  out  16  macroblocks closed in the current or last frame; saturates at 0xFFFF.
ul1ErrEarlyEnd  out  1  sticky: end flag seen before MB_PIXELS pixels.
ul1ErrMissingEnd  out  1  sticky: MB_PIXELS pixels seen without an end flag.
ul1ErrTruncated  out  1  sticky: frame ended inside a macroblock.
ul1ClearErr  in  1  clears all sticky errors.

Behaviour:
- Reset:
  - Every output is 0; FIFO is empty; pixel counter is 0; state is IDLE.
  - Reset asserted mid-frame discards the FIFO contents and any partial macroblock.
  - First cycle after reset: ul1Ready=1.
- Accept rule: a pixel is accepted on an edge where ul1Active=1 and ul1Ready=1. With ul1Ready=0 the inputs are ignored, and the source holds them.
- ul1Ready is registered from next-state occupancy: 1 iff occupancy after the edge < DEPTH. No overflow is possible.
- Output rule: a word is popped on an edge where ul1OutValid=1 and ul1OutReady=1.
  - ul1OutValid = FIFO not empty.
  - Data, type and last are stable while ul1OutValid=1 and ul1OutReady=0.
- Latency: a pixel accepted at edge N appears on the outputs after edge N, assuming the FIFO was empty.
- Simultaneous push and pop: occupancy is unchanged. Full with a pop this cycle: ul1Ready returns to 1 after that edge.
- State machine:
  - IDLE:
    - ul1Active=1 → RX.
    - On that transition: ul16MbCount←0 and pixel counter←0.
    - A pixel may be accepted on the same edge; it counts as pixel 0.
  - RX, per accepted pixel with counter value c (0..MB_PIXELS-1):
    - c=0: latch eMacroBlockType for the macroblock.
    - ul1MacroBlockEnd=1 and c=MB_PIXELS-1: normal close. Push with last=1, counter←0, MbCount+1.
    - ul1MacroBlockEnd=1 and c<MB_PIXELS-1: set ErrEarlyEnd. Push with last=1, counter←0, MbCount+1.
    - ul1MacroBlockEnd=0 and c=MB_PIXELS-1: set ErrMissingEnd. Force last=1, counter←0, MbCount+1.
    - Otherwise: push with last=0, counter+1.
  - RX with ul1Active=0 → IDLE:
    - Pulse ul1FrameDone for one cycle.
    - If counter≠0: set ErrTruncated and clear the counter. No last word is synthesised.
- FIFO words already pushed drain normally after frame end.
- Sticky errors: ul1ClearErr has priority over a set in the same cycle, i.e. the flag stays 0 that cycle.
- A type change on eMacroBlockType mid-macroblock is ignored; eOutMacroBlockType uses the latched value for every word of that macroblock.
- Counter width is clog2(MB_PIXELS). MbCount holds at 0xFFFF.

Test Plan:
- Clean frame: 2 macroblocks of 256 pixels each, data = index, end flag on pixels 255 and 511, ul1OutReady=1. Expect:
  - 512 words out in order, each 1 cycle after acceptance.
  - ul1OutLast on words 255 and 511.
  - ul16MbCount=2 and ul1FrameDone pulses once.
  - No error flags.
- Backpressure: ul1OutReady=0 for 40 cycles with ul1Active=1. Expect:
  - ul1Ready falls after exactly 16 accepts; no further acceptance.
  - Release ul1OutReady: ul1Ready returns the cycle after the first pop, and no word is lost or duplicated.
- Early end: end flag on pixel 99 of a macroblock. Expect:
  - Word 99 has last=1 and ul1ErrEarlyEnd=1.
  - The next pixel starts a new macroblock with a freshly latched type.
- Missing end: 300 pixels with no end flag. Expect:
  - Word 255 is forced last=1 and ul1ErrMissingEnd=1.
  - ul1Active drop after pixel 299 gives ul1ErrTruncated=1.
- Clear/reset: assert ul1ClearErr together with a new error event → flag stays 0. Assert ul1Reset mid-macroblock with 8 words buffered → all outputs 0, FIFO empty, and the next frame starts at counter 0.
